// File: rtl/branch_sequencer.sv
// Program-counter owner and branch sequencer: fetches in RUN, resolves one latched
// branch per request through an external comparator, flushes on taken, supports halt.
module branch_sequencer #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned RESET_PC     = 0,
    parameter int unsigned PC_STEP      = 1,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_op,
    input  logic [DATA_W-1:0] br_a,
    input  logic [DATA_W-1:0] br_b,
    input  logic [ADDR_W-1:0] br_target,
    output logic [2:0]        cmp_op,
    output logic [DATA_W-1:0] cmp_a,
    output logic [DATA_W-1:0] cmp_b,
    output logic [ADDR_W-1:0] cmp_dest,
    input  logic              cmp_pc_we,
    input  logic [ADDR_W-1:0] cmp_pc_dest,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_valid,
    output logic              flush,
    output logic              br_taken,
    output logic              halted,
    output logic [15:0]       taken_cnt
);

    typedef enum logic [1:0] {S_RUN, S_RESOLVE, S_FLUSH, S_HALT} state_t;

    localparam int unsigned FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [2:0]        r_cmp_op;
    logic [DATA_W-1:0] r_cmp_a;
    logic [DATA_W-1:0] r_cmp_b;
    logic [ADDR_W-1:0] r_cmp_dest;
    logic [FCW-1:0]    r_flush_cnt;
    logic [15:0]       r_taken_cnt;
    logic              r_br_taken;
    logic              w_run_go;
    logic              w_accept;

    assign w_run_go = (r_state == S_RUN) && !stall;
    assign w_accept = w_run_go && br_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_RUN;
        else        r_state <= w_next;
    end

    // An accepted branch takes priority over a same-cycle halt request.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN: begin
                if (w_accept)                 w_next = S_RESOLVE;
                else if (w_run_go && halt_req) w_next = S_HALT;
            end
            S_RESOLVE: begin
                if (cmp_pc_we && (FLUSH_CYCLES != 0)) w_next = S_FLUSH;
                else                                  w_next = S_RUN;
            end
            S_FLUSH: begin
                if (r_flush_cnt == FCW'(1)) w_next = S_RUN;
            end
            S_HALT: w_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= ADDR_W'(RESET_PC);
            r_cmp_op    <= 3'b111;
            r_cmp_a     <= '0;
            r_cmp_b     <= '0;
            r_cmp_dest  <= '0;
            r_flush_cnt <= '0;
            r_taken_cnt <= '0;
            r_br_taken  <= 1'b0;
        end else begin
            r_br_taken <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (w_run_go) r_pc <= r_pc + ADDR_W'(PC_STEP);
                    if (w_accept) begin
                        r_cmp_op   <= br_op;
                        r_cmp_a    <= br_a;
                        r_cmp_b    <= br_b;
                        r_cmp_dest <= br_target;
                    end
                end
                S_RESOLVE: begin
                    if (cmp_pc_we) begin
                        r_pc        <= cmp_pc_dest;
                        r_taken_cnt <= r_taken_cnt + 16'd1;
                        r_br_taken  <= 1'b1;
                        r_flush_cnt <= FCW'(FLUSH_CYCLES);
                    end
                end
                S_FLUSH: r_flush_cnt <= r_flush_cnt - FCW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        fetch_valid = rst_n && w_run_go;
        br_ready    = rst_n && w_run_go;
        flush       = (r_state == S_FLUSH);
        halted      = (r_state == S_HALT);
    end

    assign pc        = r_pc;
    assign cmp_op    = r_cmp_op;
    assign cmp_a     = r_cmp_a;
    assign cmp_b     = r_cmp_b;
    assign cmp_dest  = r_cmp_dest;
    assign br_taken  = r_br_taken;
    assign taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed scenarios followed by random
// traffic, all outputs compared every cycle against a transaction-level model.
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, stall, halt_req, br_valid, cmp_pc_we;
    logic [2:0]  br_op;
    logic [15:0] br_a, br_b, br_target, cmp_pc_dest;
    logic        br_ready, fetch_valid, flush, br_taken, halted;
    logic [2:0]  cmp_op;
    logic [15:0] cmp_a, cmp_b, cmp_dest, pc, taken_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: pc, a pending branch, remaining flush cycles, halt flag
    logic [15:0] m_pc, m_tcnt, m_a, m_b, m_dst;
    logic [2:0]  m_op;
    bit          m_halted, m_resolve, m_btaken;
    int          m_flush_left;

    branch_sequencer #(
        .ADDR_W(16), .DATA_W(16), .RESET_PC(0), .PC_STEP(1), .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .halt_req(halt_req),
        .br_valid(br_valid), .br_ready(br_ready), .br_op(br_op), .br_a(br_a),
        .br_b(br_b), .br_target(br_target), .cmp_op(cmp_op), .cmp_a(cmp_a),
        .cmp_b(cmp_b), .cmp_dest(cmp_dest), .cmp_pc_we(cmp_pc_we),
        .cmp_pc_dest(cmp_pc_dest), .pc(pc), .fetch_valid(fetch_valid),
        .flush(flush), .br_taken(br_taken), .halted(halted), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit cond_true(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b010:  return a > b;
            3'b011:  return a < b;
            3'b100:  return a >= b;
            3'b101:  return a <= b;
            3'b110:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit st, input bit hr, input bit bv,
                         input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] t);
        bit run;
        @(negedge clk);
        rst_n = rst; stall = st; halt_req = hr; br_valid = bv;
        br_op = op; br_a = a; br_b = b; br_target = t;
        // the comparator evaluates continuously on whatever branch is latched
        cmp_pc_we   = cond_true(m_op, m_a, m_b);
        cmp_pc_dest = m_dst;
        #1;
        run = !m_halted && !m_resolve && (m_flush_left == 0);
        check("pc",          pc,          m_pc);
        check("fetch_valid", fetch_valid, rst && run && !st);
        check("br_ready",    br_ready,    rst && run && !st);
        check("flush",       flush,       m_flush_left > 0);
        check("halted",      halted,      m_halted);
        check("br_taken",    br_taken,    m_btaken);
        check("taken_cnt",   taken_cnt,   m_tcnt);
        check("cmp_op",      cmp_op,      m_op);
        check("cmp_a",       cmp_a,       m_a);
        check("cmp_b",       cmp_b,       m_b);
        check("cmp_dest",    cmp_dest,    m_dst);
        @(posedge clk);
        m_btaken = 1'b0;
        if (!rst) begin
            m_pc = 16'h0; m_halted = 0; m_resolve = 0; m_flush_left = 0; m_tcnt = 16'h0;
            m_op = 3'b111; m_a = 16'h0; m_b = 16'h0; m_dst = 16'h0;
        end else if (m_halted) begin
        end else if (m_resolve) begin
            m_resolve = 0;
            if (cond_true(m_op, m_a, m_b)) begin
                m_pc = m_dst; m_tcnt = m_tcnt + 16'd1; m_btaken = 1'b1; m_flush_left = 2;
            end
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (!st) begin
            m_pc = m_pc + 16'd1;
            if (bv) begin
                m_resolve = 1; m_op = op; m_a = a; m_b = b; m_dst = t;
            end else if (hr) begin
                m_halted = 1;
            end
        end
    endtask

    task automatic idle(input int n, input bit hr);
        for (int i = 0; i < n; i++) cycle(1, 0, hr, 0, 3'b000, 16'h0, 16'h0, 16'h0);
    endtask

    initial begin
        m_pc = '0; m_tcnt = '0; m_a = '0; m_b = '0; m_dst = '0; m_op = 3'b111;
        m_halted = 0; m_resolve = 0; m_btaken = 0; m_flush_left = 0;
        cycle(0, 0, 0, 0, 3'b000, 16'h0, 16'h0, 16'h0);
        cycle(0, 0, 0, 0, 3'b000, 16'h0, 16'h0, 16'h0);
        idle(5, 0);
        cycle(1, 0, 0, 1, 3'b000, 16'd7, 16'd7, 16'h0040);   // JEQ taken at pc=5
        idle(6, 0);
        cycle(1, 0, 0, 1, 3'b011, 16'd9, 16'd3, 16'h1234);   // JLT not taken
        idle(3, 0);
        cycle(1, 0, 0, 1, 3'b111, 16'd1, 16'd1, 16'h2222);   // never-taken op
        idle(3, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 1, 3'b110, 16'h0, 16'h0, 16'h0080);
        cycle(1, 0, 0, 1, 3'b110, 16'h0, 16'h0, 16'h0080);
        idle(5, 0);
        cycle(1, 0, 1, 1, 3'b110, 16'h0, 16'h0, 16'h0020);   // branch beats halt
        idle(6, 1);
        cycle(0, 0, 0, 0, 3'b000, 16'h0, 16'h0, 16'h0);
        cycle(1, 0, 0, 1, 3'b110, 16'h0, 16'h0, 16'hFFFF);
        idle(5, 0);                                          // wraps past 0xFFFF
        cycle(1, 0, 0, 1, 3'b110, 16'h0, 16'h0, 16'h0100);
        idle(2, 0);
        cycle(0, 0, 0, 0, 3'b000, 16'h0, 16'h0, 16'h0);      // reset mid-flush
        idle(3, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] tgt;
            tgt = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom);
            cycle(($urandom % 100) >= 3, ($urandom % 4) == 0, ($urandom % 50) == 0,
                  ($urandom % 3) == 0, 3'($urandom % 8), 16'($urandom % 4),
                  16'($urandom % 4), tgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
